framebuffer_writer: RTL and testbench

- Upstream feeder of the PSRAM framebuffer that the HDMI-side framebuffer reader consumes.
- Accepts an RGB565 pixel stream from the SPI command decoder and packs 4 pixels into each 64-bit word.
- Collects 8 words into one 64-byte burst, using ping-pong burst buffers.
- Issues PSRAM write bursts with the same cmd/busy/done protocol the PSRAM controller presents to the reader, sequentially and wrapping inside the framebuffer.

---
 rtl/framebuffer_writer.sv | 183 ++++++++++++++++++
 tb/tb_framebuffer_writer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/framebuffer_writer.sv
// Packs an RGB565 pixel stream into 64-byte ping-pong bursts and writes them
// sequentially into a wrapping PSRAM framebuffer.
//
// state  | meaning
// IDLE   | waiting for a pending buffer and a non-busy controller
// REQ    | one-cycle write command, address valid
// XFER   | supplying 8 data beats on controller strobes
// WAIT   | beats delivered, waiting for burst completion
module framebuffer_writer #(
   parameter int ADDR_W   = 21,
   parameter int FB_BASE  = 0,
   parameter int FB_BYTES = 153600
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_frame_start,
   input  logic              i_flush,
   input  logic              i_pix_valid,
   input  logic [15:0]       i_pix_data,
   output logic              o_pix_ready,
   input  logic              i_psram_busy,
   output logic              o_psram_req,
   output logic [ADDR_W-1:0] o_psram_addr,
   input  logic              i_psram_data_req,
   output logic [63:0]       o_psram_wr_data,
   output logic [7:0]        o_psram_wr_mask,
   input  logic              i_psram_done,
   output logic              o_idle
);

   localparam logic [ADDR_W-1:0] BASE        = ADDR_W'(FB_BASE);
   localparam logic [ADDR_W-1:0] FB_END      = ADDR_W'(FB_BASE + FB_BYTES);
   localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(64);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_WAIT} state_t;

   state_t            state_q, state_d;
   logic              fill_sel_q, fill_sel_d;
   logic [5:0]        fill_cnt_q, fill_cnt_d;
   logic [1:0]        pend_q, pend_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [ADDR_W-1:0] baddr_q [2];
   logic [ADDR_W-1:0] baddr_d [2];
   logic [5:0]        bcnt_q [2];
   logic [5:0]        bcnt_d [2];
   logic              cur_sel_q, cur_sel_d;
   logic [2:0]        beat_q, beat_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [15:0]       pix_mem_q [2][32];

   logic              pix_accept;
   logic              other_free;
   logic [4:0]        wr_idx;
   logic [5:0]        cnt_next;
   logic [ADDR_W-1:0] ptr_inc;
   logic [ADDR_W-1:0] ptr_adv;
   logic              issue_sel;
   logic [4:0]        slot;

   assign o_pix_ready  = !pend_q[fill_sel_q];
   assign pix_accept   = i_pix_valid && o_pix_ready;
   assign other_free   = !pend_q[~fill_sel_q] &&
                         !((state_q != S_IDLE) && (cur_sel_q == ~fill_sel_q));
   assign wr_idx       = i_frame_start ? 5'd0 : fill_cnt_q[4:0];
   assign o_psram_req  = (state_q == S_REQ);
   assign o_psram_addr = addr_q;
   assign o_idle       = (state_q == S_IDLE) && (pend_q == 2'b00) && (fill_cnt_q == 6'd0);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= S_IDLE;
         fill_sel_q <= 1'b0;
         fill_cnt_q <= '0;
         pend_q     <= '0;
         ptr_q      <= BASE;
         cur_sel_q  <= 1'b0;
         beat_q     <= '0;
         addr_q     <= '0;
         for (int b = 0; b < 2; b++) begin
            baddr_q[b] <= '0;
            bcnt_q[b]  <= '0;
         end
      end else begin
         state_q    <= state_d;
         fill_sel_q <= fill_sel_d;
         fill_cnt_q <= fill_cnt_d;
         pend_q     <= pend_d;
         ptr_q      <= ptr_d;
         cur_sel_q  <= cur_sel_d;
         beat_q     <= beat_d;
         addr_q     <= addr_d;
         for (int b = 0; b < 2; b++) begin
            baddr_q[b] <= baddr_d[b];
            bcnt_q[b]  <= bcnt_d[b];
         end
      end
   end

   // Pixel storage needs no reset: unfilled slots are masked and zeroed on read.
   always_ff @(posedge i_clk) begin
      if (pix_accept) pix_mem_q[fill_sel_q][wr_idx] <= i_pix_data;
   end

   always_comb begin
      fill_sel_d = fill_sel_q;
      fill_cnt_d = fill_cnt_q;
      pend_d     = pend_q;
      ptr_d      = ptr_q;
      baddr_d    = baddr_q;
      bcnt_d     = bcnt_q;
      state_d    = state_q;
      cur_sel_d  = cur_sel_q;
      beat_d     = beat_q;
      addr_d     = addr_q;
      issue_sel  = 1'b0;

      cnt_next = (i_frame_start ? 6'd0 : fill_cnt_q) + {5'd0, pix_accept};
      ptr_inc  = ptr_q + BURST_BYTES;
      ptr_adv  = (ptr_inc == FB_END) ? BASE : ptr_inc;

      if (i_frame_start) begin
         pend_d     = 2'b00;
         ptr_d      = BASE;
         fill_cnt_d = cnt_next;
      end else if ((cnt_next == 6'd32) || (i_flush && (cnt_next != 6'd0))) begin
         pend_d[fill_sel_q]  = 1'b1;
         baddr_d[fill_sel_q] = ptr_q;
         bcnt_d[fill_sel_q]  = cnt_next;
         ptr_d               = ptr_adv;
         fill_cnt_d          = 6'd0;
         if (other_free) fill_sel_d = ~fill_sel_q;
      end else begin
         fill_cnt_d = cnt_next;
         if (pend_q[fill_sel_q] && other_free) fill_sel_d = ~fill_sel_q;
      end

      case (state_q)
         S_IDLE: begin
            // With both pending, the fill side is parked on the newer one.
            if ((pend_q != 2'b00) && !i_psram_busy && !i_frame_start) begin
               issue_sel         = (pend_q == 2'b11) ? ~fill_sel_q : pend_q[1];
               cur_sel_d         = issue_sel;
               pend_d[issue_sel] = 1'b0;
               addr_d            = baddr_q[issue_sel];
               beat_d            = 3'd0;
               state_d           = S_REQ;
            end
         end
         S_REQ: begin
            beat_d  = 3'd0;
            state_d = S_XFER;
         end
         S_XFER: begin
            if (i_psram_done) begin
               state_d = S_IDLE;
            end else if (i_psram_data_req) begin
               if (beat_q == 3'd7) state_d = S_WAIT;
               else                beat_d  = beat_q + 3'd1;
            end
         end
         S_WAIT: begin
            if (i_psram_done) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      o_psram_wr_data = '0;
      o_psram_wr_mask = 8'hFF;
      slot            = '0;
      if (state_q == S_XFER) begin
         for (int k = 0; k < 4; k++) begin
            slot = {beat_q, 2'(k)};
            if ({1'b0, slot} < bcnt_q[cur_sel_q]) begin
               o_psram_wr_data[16*k +: 16] = pix_mem_q[cur_sel_q][slot];
               o_psram_wr_mask[2*k +: 2]   = 2'b00;
            end
         end
      end
   end

endmodule

// File: tb/tb_framebuffer_writer.sv
// Directed bench for framebuffer_writer: a PSRAM controller model captures each
// burst and checks it against expected bursts queued as pixels are driven.
module tb_framebuffer_writer;

   localparam int ADDR_W   = 21;
   localparam int NBURST   = 40;
   localparam int FB_BYTES = NBURST * 64;   // small framebuffer so the wrap is reached quickly

   logic              i_clk = 1'b0;
   logic              i_rst;
   logic              i_frame_start;
   logic              i_flush;
   logic              i_pix_valid;
   logic [15:0]       i_pix_data;
   logic              o_pix_ready;
   logic              i_psram_busy;
   logic              o_psram_req;
   logic [ADDR_W-1:0] o_psram_addr;
   logic              i_psram_data_req;
   logic [63:0]       o_psram_wr_data;
   logic [7:0]        o_psram_wr_mask;
   logic              i_psram_done;
   logic              o_idle;

   always #5 i_clk = ~i_clk;

   framebuffer_writer #(.ADDR_W(ADDR_W), .FB_BASE(0), .FB_BYTES(FB_BYTES)) dut (
      .i_clk            (i_clk),
      .i_rst            (i_rst),
      .i_frame_start    (i_frame_start),
      .i_flush          (i_flush),
      .i_pix_valid      (i_pix_valid),
      .i_pix_data       (i_pix_data),
      .o_pix_ready      (o_pix_ready),
      .i_psram_busy     (i_psram_busy),
      .o_psram_req      (o_psram_req),
      .o_psram_addr     (o_psram_addr),
      .i_psram_data_req (i_psram_data_req),
      .o_psram_wr_data  (o_psram_wr_data),
      .o_psram_wr_mask  (o_psram_wr_mask),
      .i_psram_done     (i_psram_done),
      .o_idle           (o_idle)
   );

   typedef struct {
      logic [ADDR_W-1:0]  addr;
      logic [7:0][63:0]   data;
      logic [7:0][7:0]    mask;
   } burst_t;

   burst_t            sb[$];
   int                n_tests = 0;
   int                n_fail  = 0;
   logic [15:0]       pv      = 16'h0000;
   int                stall_cnt = 0;
   int                tcmd    = 10;
   int                bstart  = 1;
   int                ctl_t   = 0;
   int                ctl_beat = 0;
   bit                ctl_active = 1'b0;
   logic [63:0]       cap_data [8];
   logic [7:0]        cap_mask [8];
   logic [ADDR_W-1:0] cap_addr;
   logic [15:0]       p0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      assert (got === exp)
      else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic push_exp(input logic [ADDR_W-1:0] a, input logic [15:0] first, input int n);
      burst_t e;
      e.addr = a;
      for (int w = 0; w < 8; w++) begin
         for (int k = 0; k < 4; k++) begin
            if (4*w + k < n) begin
               e.data[w][16*k +: 16] = first + 16'(4*w + k);
               e.mask[w][2*k +: 2]   = 2'b00;
            end else begin
               e.data[w][16*k +: 16] = 16'h0000;
               e.mask[w][2*k +: 2]   = 2'b11;
            end
         end
      end
      sb.push_back(e);
   endtask

   task automatic compare_burst();
      burst_t e;
      check("burst_expected", (sb.size() > 0), 1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check("burst_addr", cap_addr, e.addr);
         check("addr_hold", o_psram_addr, cap_addr);
         for (int b = 0; b < 8; b++) begin
            check($sformatf("beat%0d_data", b), cap_data[b], e.data[b]);
            check($sformatf("beat%0d_mask", b), cap_mask[b], e.mask[b]);
         end
      end
   endtask

   // PSRAM controller model: busy from req until done, beats from t=bstart, done at t=tcmd.
   initial begin
      i_psram_busy     = 1'b0;
      i_psram_data_req = 1'b0;
      i_psram_done     = 1'b0;
      forever begin
         @(negedge i_clk);
         i_psram_data_req = 1'b0;
         i_psram_done     = 1'b0;
         if (i_rst) begin
            ctl_active   = 1'b0;
            i_psram_busy = 1'b0;
            ctl_t        = 0;
         end else if (!ctl_active) begin
            if (o_psram_req) begin
               check("req_while_busy", i_psram_busy, 0);
               ctl_active   = 1'b1;
               ctl_t        = 0;
               ctl_beat     = 0;
               i_psram_busy = 1'b1;
               cap_addr     = o_psram_addr;
            end
         end else begin
            ctl_t++;
            if (ctl_t == 1) check("req_one_cycle", o_psram_req, 0);
            if (ctl_t >= bstart && ctl_beat < 8) begin
               i_psram_data_req   = 1'b1;
               cap_data[ctl_beat] = o_psram_wr_data;
               cap_mask[ctl_beat] = o_psram_wr_mask;
               ctl_beat++;
               if (ctl_beat == 8) compare_burst();
            end
            if (ctl_t >= tcmd) begin
               i_psram_done = 1'b1;
               i_psram_busy = 1'b0;
               ctl_active   = 1'b0;
            end
         end
      end
   end

   task automatic send_pix(input int n, input bit flush_last, input bit fs_first);
      int sent  = 0;
      int guard = 0;
      while (sent < n && guard < 2000) begin
         i_flush       = 1'b0;
         i_frame_start = 1'b0;
         if (o_pix_ready) begin
            i_pix_valid = 1'b1;
            i_pix_data  = pv;
            if (sent == 0 && fs_first) i_frame_start = 1'b1;
            pv++;
            sent++;
            if (sent == n && flush_last) i_flush = 1'b1;
         end else begin
            i_pix_valid = 1'b0;
            stall_cnt++;
         end
         @(negedge i_clk);
         guard++;
      end
      i_pix_valid   = 1'b0;
      i_flush       = 1'b0;
      i_frame_start = 1'b0;
      check("pix_sent", sent, n);
   endtask

   task automatic wait_idle(input string tag);
      int g = 0;
      while (!(o_idle && !ctl_active) && g < 1000) begin
         @(negedge i_clk);
         g++;
      end
      check({tag, "_idle"}, o_idle, 1);
      check({tag, "_sb_empty"}, sb.size(), 0);
   endtask

   task automatic do_reset();
      i_rst         = 1'b1;
      i_pix_valid   = 1'b0;
      i_flush       = 1'b0;
      i_frame_start = 1'b0;
      repeat (2) @(negedge i_clk);
      i_rst = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      i_pix_data = 16'h0000;
      do_reset();
      check("rst_pix_ready", o_pix_ready, 1);
      check("rst_idle", o_idle, 1);
      check("rst_req", o_psram_req, 0);
      check("rst_addr", o_psram_addr, 0);
      check("rst_wr_data", o_psram_wr_data, 0);

      // single full burst, pixels 0x0000..0x001F
      push_exp(0, pv, 32);
      send_pix(32, 1'b0, 1'b0);
      wait_idle("t1");
      check("t1_beat0", cap_data[0], 64'h0003000200010000);
      check("t1_beat7", cap_data[7], 64'h001F001E001D001C);
      check("t1_mask3", cap_mask[3], 8'h00);

      // slow controller so both buffers fill and the stream stalls
      do_reset();
      tcmd = 40;
      stall_cnt = 0;
      push_exp(0,   pv,          32);
      push_exp(64,  pv + 16'd32, 32);
      push_exp(128, pv + 16'd64, 32);
      send_pix(96, 1'b0, 1'b0);
      check("t2_stall_seen", (stall_cnt > 0), 1);
      wait_idle("t2");
      tcmd = 10;

      // partial burst flushed together with its last pixel
      do_reset();
      p0 = pv;
      push_exp(0, p0, 5);
      send_pix(5, 1'b1, 1'b0);
      wait_idle("t3_flush");
      check("t3_mask0", cap_mask[0], 8'h00);
      check("t3_mask1", cap_mask[1], 8'hFC);
      check("t3_mask2", cap_mask[2], 8'hFF);
      check("t3_mask7", cap_mask[7], 8'hFF);
      check("t3_data1", cap_data[1], {48'h0, p0 + 16'd4});
      i_flush = 1'b1;
      @(negedge i_clk);
      i_flush = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("t3_empty_flush_req", o_psram_req, 0);
         check("t3_empty_flush_idle", o_idle, 1);
         @(negedge i_clk);
      end
      push_exp(64, pv, 32);
      send_pix(32, 1'b0, 1'b0);
      wait_idle("t3_next");
      // 7 buffered pixels discarded by a frame_start carrying the new frame's first pixel
      send_pix(7, 1'b0, 1'b0);
      push_exp(0, pv, 32);
      send_pix(32, 1'b0, 1'b1);
      wait_idle("t3_fs_pixel");

      // pointer wrap without frame_start, then frame_start+flush mid-fill
      do_reset();
      for (int b = 0; b <= NBURST; b++) begin
         push_exp(ADDR_W'((b % NBURST) * 64), pv, 32);
         send_pix(32, 1'b0, 1'b0);
      end
      wait_idle("t4_wrap");
      check("t4_wrap_addr", cap_addr, 0);
      send_pix(10, 1'b0, 1'b0);
      i_frame_start = 1'b1;
      i_flush       = 1'b1;
      @(negedge i_clk);
      i_frame_start = 1'b0;
      i_flush       = 1'b0;
      check("t4_fs_beats_flush", o_idle, 1);
      push_exp(0, pv, 32);
      send_pix(32, 1'b0, 1'b0);
      wait_idle("t4_after_fs");

      // frame_start while a burst is in XFER and another buffer is pending
      do_reset();
      bstart = 40;
      tcmd   = 50;
      push_exp(0, pv, 32);
      send_pix(64, 1'b0, 1'b0);
      check("t5_ready_low", o_pix_ready, 0);
      check("t5_in_xfer_mask", o_psram_wr_mask, 8'h00);
      i_frame_start = 1'b1;
      @(negedge i_clk);
      i_frame_start = 1'b0;
      check("t5_ready_after_fs", o_pix_ready, 1);
      push_exp(0, pv, 32);
      send_pix(32, 1'b0, 1'b0);
      wait_idle("t5");
      bstart = 1;

      // reset while waiting for done
      do_reset();
      tcmd = 30;
      push_exp(0, pv, 32);
      send_pix(32, 1'b0, 1'b0);
      for (int g = 0; g < 200 && ctl_t < 15; g++) @(negedge i_clk);
      check("t6_reached_wait", (ctl_t >= 15), 1);
      i_rst = 1'b1;
      @(negedge i_clk);
      check("t6_rst_ready", o_pix_ready, 1);
      check("t6_rst_idle", o_idle, 1);
      check("t6_rst_req", o_psram_req, 0);
      i_rst = 1'b0;
      tcmd  = 10;
      push_exp(0, pv, 32);
      send_pix(32, 1'b0, 1'b0);
      wait_idle("t6");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
